// File: rtl/dl_ram_writer.sv
// dl_ram_writer
//   Write-side stage behind the SPI download receiver. Byte write strobes
//   (address + data) are queued in a small FIFO and replayed to the shared
//   RAM controller through a level request / one-cycle acknowledge
//   handshake. Strobes are therefore not lost while the controller is busy
//   with CPU or video cycles. The block also produces the CPU-hold and
//   download-complete signals used around a ROM/tape load.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset        synchronous active-low reset (0 = reset)
//   downloading  download-active level from the receiver
//   in_wr        one-cycle write strobe; in_a / in_d valid with it
//   mem_req      RAM write request (level); mem_a / mem_d stable while high
//   mem_ack      one-cycle acknowledge from the RAM controller
//   cpu_hold     registered: download active, FIFO non-empty or request out
//   dl_done      one-cycle pulse once a finished download is fully in RAM
//   overflow     sticky: a strobe was dropped because the FIFO was full
//   level        current FIFO occupancy
//   checksum     running byte sum of acknowledged writes
//
// Build option
//   DL_RAM_WRITER_CHECKSUM_EN  when defined, checksum is the 16-bit
//   wrap-around sum of every acknowledged byte since the last rising edge
//   of downloading. When undefined, checksum is tied to zero.

module dl_ram_writer #(
  parameter int DEPTH_LOG2 = 3,
  parameter int AW         = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  downloading,
  input  logic                  in_wr,
  input  logic [AW-1:0]         in_a,
  input  logic [7:0]            in_d,
  output logic                  mem_req,
  output logic [AW-1:0]         mem_a,
  output logic [7:0]            mem_d,
  input  logic                  mem_ack,
  output logic                  cpu_hold,
  output logic                  dl_done,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   level,
  output logic [15:0]           checksum
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] ONE        = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LAST_PTR   = (DEPTH_LOG2+1)'(DEPTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]            state;
  logic [AW+7:0]         fifo_mem [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic                  nonempty_q;
  logic                  dl_q;
  logic                  pending;

  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  dl_rise;
  logic [AW+7:0]         head;

  // Pointers run 0..DEPTH-1 and wrap back to zero.
  function automatic logic [DEPTH_LOG2:0] next_ptr(input logic [DEPTH_LOG2:0] p);
    return (p == LAST_PTR) ? '0 : p + ONE;
  endfunction

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign pop     = (state == ST_REQ) && mem_ack;
  // A pop in the same cycle frees the slot, so a strobe at full still fits.
  assign push    = in_wr && (!full || pop);
  assign drop    = in_wr && full && !pop;
  assign dl_rise = downloading && !dl_q;
  assign head    = fifo_mem[rd_ptr[DEPTH_LOG2-1:0]];

  // NOTE: the storage array has no reset; an entry is only ever read after
  // it was written, so clearing it would only cost a reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[DEPTH_LOG2-1:0]] <= {in_a, in_d};
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      nonempty_q <= 1'b0;
      mem_req    <= 1'b0;
      mem_a      <= '0;
      mem_d      <= '0;
      cpu_hold   <= 1'b0;
      dl_done    <= 1'b0;
      overflow   <= 1'b0;
      pending    <= 1'b0;
      dl_q       <= 1'b0;
    end else begin
      dl_q     <= downloading;
      cpu_hold <= downloading || !empty || mem_req;

      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);

      case ({push, pop})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase

      // Occupancy as seen one cycle late: a fresh strobe reaches mem_req two
      // edges after it is sampled. Only REQ pops, and REQ is always followed
      // by GAP, so a stale "non-empty" can never be seen in IDLE.
      nonempty_q <= !empty;

      case (state)
        ST_IDLE: begin
          if (nonempty_q) begin
            mem_a   <= head[AW+7:8];
            mem_d   <= head[7:0];
            mem_req <= 1'b1;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase

      // A new download clears the sticky flag; a drop in the same cycle
      // still wins so it is never hidden.
      if (dl_rise)   overflow <= 1'b0;
      if (drop)      overflow <= 1'b1;

      dl_done <= 1'b0;
      if (dl_rise) begin
        pending <= 1'b1;
      end else if (pending && !downloading && empty && (state == ST_IDLE)) begin
        pending <= 1'b0;
        dl_done <= 1'b1;
      end
    end
  end

`ifdef DL_RAM_WRITER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      checksum <= '0;
    end else if (dl_rise) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + {8'h00, mem_d};
    end
  end
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_dl_ram_writer.sv
// tb_dl_ram_writer
//   Directed bench for dl_ram_writer. Every accepted strobe pushes its
//   expected {address, data} into a queue; a monitor pops and compares each
//   time a new RAM request appears. A responder task acknowledges requests
//   with zero wait when enabled.

module tb_dl_ram_writer;

  localparam int AW = 25;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  logic          clk;
  logic          reset;
  logic          downloading;
  logic          in_wr;
  logic [AW-1:0] in_a;
  logic [7:0]    in_d;
  logic          mem_req;
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_d;
  logic          mem_ack;
  logic          cpu_hold;
  logic          dl_done;
  logic          overflow;
  logic [3:0]    level;
  logic [15:0]   checksum;

  int  checks;
  int  failures;
  wr_t exp_q[$];
  int  req_count;
  int  dl_done_cnt;
  bit  ack_en;
  logic [15:0] exp_sum;

  dl_ram_writer #(.DEPTH_LOG2(3), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .downloading (downloading),
    .in_wr       (in_wr),
    .in_a        (in_a),
    .in_d        (in_d),
    .mem_req     (mem_req),
    .mem_a       (mem_a),
    .mem_d       (mem_d),
    .mem_ack     (mem_ack),
    .cpu_hold    (cpu_hold),
    .dl_done     (dl_done),
    .overflow    (overflow),
    .level       (level),
    .checksum    (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the strobe is sampled on the following posedge.
  task automatic strobe(input logic [AW-1:0] a, input logic [7:0] d, input bit accept);
    wr_t e;
    in_wr = 1'b1;
    in_a  = a;
    in_d  = d;
    if (accept) begin
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_wr = 1'b0;
  endtask

  // Zero-wait acknowledge: raise ack in the first cycle mem_req is seen.
  task automatic ack_responder();
    forever begin
      @(negedge clk);
      if (ack_en) mem_ack = mem_req && !mem_ack;
    end
  endtask

  // Scoreboard monitor: compare each newly presented request with the queue.
  task automatic monitor();
    logic req_prev;
    wr_t  e;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (mem_req && !req_prev) begin
          req_count++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL req_unexpected actual a=%0h d=%0h required=no request", mem_a, mem_d);
          end else begin
            e = exp_q.pop_front();
            check("req_addr", 64'(mem_a), 64'(e.a));
            check("req_data", 64'(mem_d), 64'(e.d));
          end
        end
        if (dl_done) dl_done_cnt++;
      end
      req_prev = mem_req;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  req_base;
    int  dd_base;
    bit  hold_ok;

    checks      = 0;
    failures    = 0;
    req_count   = 0;
    dl_done_cnt = 0;
    ack_en      = 1'b0;
    reset       = 1'b0;
    downloading = 1'b0;
    in_wr       = 1'b0;
    in_a        = '0;
    in_d        = '0;
    mem_ack     = 1'b0;
`ifdef DL_RAM_WRITER_CHECKSUM_EN
    exp_sum = 16'h000A;
`else
    exp_sum = 16'h0000;
`endif

    fork
      ack_responder();
      monitor();
    join_none

    // Reset state, sampled while reset is held.
    repeat (3) @(negedge clk);
    check("rst_mem_req",  64'(mem_req),  64'(0));
    check("rst_mem_a",    64'(mem_a),    64'(0));
    check("rst_mem_d",    64'(mem_d),    64'(0));
    check("rst_level",    64'(level),    64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_dl_done",  64'(dl_done),  64'(0));
    check("rst_cpu_hold", 64'(cpu_hold), 64'(0));
    check("rst_checksum", 64'(checksum), 64'(0));
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte with zero-wait ack: request after edge N+2, pop at N+3.
    ack_en = 1'b1;
    strobe(25'h100000, 8'hC3, 1'b1);           // now after edge N
    @(negedge clk);                            // after N+1
    check("t1_req_n1", 64'(mem_req), 64'(0));
    @(negedge clk);                            // after N+2
    check("t1_req_n2", 64'(mem_req), 64'(1));
    check("t1_addr",   64'(mem_a),   64'(25'h100000));
    check("t1_data",   64'(mem_d),   64'(8'hC3));
    @(negedge clk);                            // after N+3: acked
    check("t1_req_gap", 64'(mem_req), 64'(0));
    check("t1_level",   64'(level),   64'(0));
    @(negedge clk);
    check("t1_req_idle", 64'(mem_req), 64'(0));
    repeat (3) @(negedge clk);

    // Burst fill with ack held low.
    ack_en  = 1'b0;
    mem_ack = 1'b0;
    req_base = req_count;
    for (int i = 0; i < 8; i++) begin
      strobe(25'h000200 + 25'(i), 8'h10 + 8'(i), 1'b1);
    end
    check("fill_level",    64'(level),    64'(8));
    check("fill_overflow", 64'(overflow), 64'(0));
    check("fill_req",      64'(mem_req),  64'(1));

    // Strobe coinciding with an ack at full: accepted, level unchanged.
    mem_ack = 1'b1;
    strobe(25'h0003AA, 8'h5A, 1'b1);
    mem_ack = 1'b0;
    check("pp_level",    64'(level),    64'(8));
    check("pp_overflow", 64'(overflow), 64'(0));

    // Strobe at full with no pop (FSM in GAP): dropped.
    strobe(25'h0003BB, 8'hEE, 1'b0);
    check("drop_level",    64'(level),    64'(8));
    check("drop_overflow", 64'(overflow), 64'(1));

    // Release the controller; the remaining eight drain in order.
    ack_en = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("burst_drained", 64'(exp_q.size()),        64'(0));
    check("burst_reqs",    64'(req_count - req_base), 64'(9));
    check("burst_level",   64'(level),               64'(0));
    check("burst_sticky",  64'(overflow),            64'(1));

    // Download cycle: 4 bytes, downloading drops before the drain ends.
    req_base = req_count;
    dd_base  = dl_done_cnt;
    downloading = 1'b1;
    @(negedge clk);                            // after rising-edge sample
    check("dl_ovf_clear", 64'(overflow), 64'(0));
    check("dl_sum_clear", 64'(checksum), 64'(0));
    check("dl_hold_on",   64'(cpu_hold), 64'(1));
    for (int i = 0; i < 4; i++) begin
      strobe(25'h000040 + 25'(i), 8'(i + 1), 1'b1);
    end
    downloading = 1'b0;
    hold_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!cpu_hold) hold_ok = 1'b0;
      if (exp_q.size() == 0 && !mem_req) break;
      @(negedge clk);
    end
    // Now one cycle after the last ack edge M.
    check("dl_drained",   64'(exp_q.size()), 64'(0));
    check("dl_hold_kept", 64'(hold_ok),      64'(1));
    check("dl_reqs",      64'(req_count - req_base), 64'(4));
    @(negedge clk);                            // after M+1 (GAP -> IDLE)
    check("dl_done_early", 64'(dl_done), 64'(0));
    @(negedge clk);                            // after M+2
    check("dl_done_pulse", 64'(dl_done),  64'(1));
    check("dl_hold_off",   64'(cpu_hold), 64'(0));
    check("dl_checksum",   64'(checksum), 64'(exp_sum));
    repeat (5) @(negedge clk);
    check("dl_done_count", 64'(dl_done_cnt - dd_base), 64'(1));

    // Reset in the middle of a handshake with three entries queued.
    ack_en  = 1'b0;
    mem_ack = 1'b0;
    downloading = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      strobe(25'h000080 + 25'(i), 8'hA0 + 8'(i), 1'b1);
    end
    downloading = 1'b0;
    check("mid_req",   64'(mem_req), 64'(1));
    check("mid_level", 64'(level),   64'(3));
    reset = 1'b0;
    @(negedge clk);
    check("mr_req",      64'(mem_req),  64'(0));
    check("mr_level",    64'(level),    64'(0));
    check("mr_overflow", 64'(overflow), 64'(0));
    check("mr_checksum", 64'(checksum), 64'(0));
    reset = 1'b1;
    exp_q.delete();
    req_base = req_count;
    dd_base  = dl_done_cnt;
    repeat (20) @(negedge clk);
    check("mr_no_dl_done", 64'(dl_done_cnt - dd_base), 64'(0));
    check("mr_no_req",     64'(req_count - req_base),  64'(0));
    check("mr_hold",       64'(cpu_hold),              64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dl_ram_writer.md
# dl_ram_writer

Write-side stage directly downstream of the SPI download receiver. Captures the receiver's single-cycle byte write strobes (address + data) into a small FIFO and replays them to the shared RAM controller through a request/acknowledge handshake, so bytes are not lost while the controller serves CPU or video cycles. Also produces the CPU-hold and download-complete signals the core uses around a ROM/tape load.

## Interface
Parameters:
- `DEPTH_LOG2`, 3, FIFO depth = 2^DEPTH_LOG2 entries (8).
- `AW`, 25, address width; matches the receiver's address bus.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset), sampled on `clk`.
- `downloading`  in  1  download-active level from the receiver.
- `in_wr`  in  1  one-cycle write strobe from the receiver.
- `in_a`  in  AW  write address, valid with `in_wr`.
- `in_d`  in  8  write data, valid with `in_wr`.
- `mem_req`  out  1  RAM write request, level.
- `mem_a`  out  AW  RAM address, stable while `mem_req`=1.
- `mem_d`  out  8  RAM data, stable while `mem_req`=1.
- `mem_ack`  in  1  one-cycle acknowledge from RAM controller.
- `cpu_hold`  out  1  1 while `downloading`=1 or FIFO non-empty or `mem_req`=1.
- `dl_done`  out  1  one-cycle pulse when a download has fully drained to RAM.
- `overflow`  out  1  sticky: a strobe was dropped because the FIFO was full.
- `level`  out  DEPTH_LOG2+1  current FIFO occupancy.
- `checksum`  out  16  running byte sum (see Configuration).

## Operation
- FIFO of {in_a, in_d}; write pointer, read pointer, occupancy counter, DEPTH_LOG2+1 bits each (pointers wrap modulo depth).
- Push: `in_wr`=1 and (not full, or a pop occurs the same cycle). Push while full with no pop: entry dropped, `overflow` set.
- Pop: occurs in the cycle `mem_ack`=1 is sampled in state REQ.
- Simultaneous push and pop: both performed, `level` unchanged.
- FSM states:
  - IDLE: `mem_req`=0. If FIFO non-empty: load head into `mem_a`/`mem_d`, go REQ.
  - REQ: `mem_req`=1, address/data held. On `mem_ack`=1: pop, go GAP. `mem_ack` in IDLE/GAP ignored.
  - GAP: `mem_req`=0 for exactly one cycle, then IDLE.
- Download tracking: registered copy `dl_q` of `downloading`.
  - Rising edge: clear `overflow` and `checksum`; set `pending`.
  - `pending`=1, `downloading`=0, FIFO empty, state IDLE: pulse `dl_done`, clear `pending`.
- Strobes accepted regardless of `downloading` level.
- Reset (any state, including mid-handshake): pointers/level 0, state IDLE, `mem_req`=0, `mem_a`=0, `mem_d`=0, `dl_done`=0, `overflow`=0, `pending`=0, `dl_q`=0, `checksum`=0. A pending RAM access is abandoned; the controller must tolerate a dropped request.

## Timing
- All outputs registered; `cpu_hold` registered from the same-cycle conditions (one cycle delay).
- Empty FIFO, IDLE: `in_wr` sampled at edge N → `mem_req`=1 after edge N+2.
- `mem_ack` sampled at edge M → `mem_req`=0 after M; next request no earlier than after edge M+2.
- Peak throughput: one byte per 3 cycles with zero-wait `mem_ack`.
- `dl_done` earliest: one cycle after the last ack's GAP completes, with `downloading` already low.

## Configuration
- `DL_RAM_WRITER_CHECKSUM_EN` defined: `checksum` = 16-bit wrap-around sum of `mem_d` over every acknowledged write since the last `downloading` rising edge; updated in the ack cycle.
- Not defined: checksum adder absent, `checksum` tied to 16'h0000.

## Test plan
- Single byte: `in_wr` with a=25'h100000, d=8'hC3, `mem_ack` same cycle as `mem_req` → one request with a=25'h100000/d=C3 two cycles after strobe, `level` back to 0, `mem_req` low for one GAP cycle.
- Burst fill: 8 strobes on consecutive cycles, `mem_ack` held 0 → `level`=8, `overflow`=0; ninth strobe → dropped, `overflow`=1; release ack → exactly 8 writes in original order.
- Push+pop same cycle at full: strobe coincides with `mem_ack` at `level`=8 → accepted, `level` stays 8, `overflow`=0.
- Download cycle: `downloading` 0→1, 4 bytes 01,02,03,04, `downloading` 1→0 before drain → `cpu_hold`=1 throughout, single `dl_done` pulse after last ack; `checksum`=16'h000A with macro, 0 without.
- Reset mid-handshake: `reset`=0 while in REQ with `level`=3 → next cycle `mem_req`=0, `level`=0, `overflow`=0; no `dl_done` pulse afterwards.
